// File: rtl/adder_arbiter.sv
// ---------------------------------------------------------------------------
// adder_arbiter
//   Shares one K-bit unsigned adder between two requesters. A three-state
//   FSM (IDLE -> ADD -> RESP) accepts one operand pair at a time, arbitrates
//   round-robin between the requesters, and returns the (K+1)-bit sum
//   together with the id of the requester that owns it.
//
// Ports
//   clk, resetn              : clock, asynchronous active-low reset
//   req0_valid/_a/_b/_ready  : requester 0 operand channel
//   req1_valid/_a/_b/_ready  : requester 1 operand channel
//   resp_valid/_ready        : result handshake toward the consumer
//   resp_sum                 : a + b, bit K is the carry out
//   resp_id                  : requester index owning resp_sum
// ---------------------------------------------------------------------------

// Plain unsigned adder; the carry out is kept as the top result bit.
module generic_adder #(
  parameter int K = 6
) (
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter int K = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         req0_valid,
  input  logic [K-1:0] req0_a,
  input  logic [K-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [K-1:0] req1_a,
  input  logic [K-1:0] req1_b,
  output logic         req1_ready,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [K:0]   resp_sum,
  output logic         resp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_reg;
  logic         last_grant_reg;
  logic [K-1:0] op_a_reg;
  logic [K-1:0] op_b_reg;
  logic         op_id_reg;
  logic         resp_valid_reg;
  logic [K:0]   resp_sum_reg;
  logic         resp_id_reg;

  logic         grant0;
  logic         grant1;
  logic [K:0]   adder_sum;

  // Round-robin: a lone valid requester always wins; under contention the
  // requester that was not granted last time wins. The two terms are
  // mutually exclusive, so at most one grant is ever active.
  assign grant0 = req0_valid && (!req1_valid || last_grant_reg);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_reg);

  // Ready is combinational in IDLE. It is also gated by resetn because the
  // state register already reads IDLE while reset is held low, and no
  // requester may see ready during reset.
  assign req0_ready = resetn && (state_reg == IDLE) && grant0;
  assign req1_ready = resetn && (state_reg == IDLE) && grant1;

  // The single shared adder always works on the latched operands, so input
  // changes after the handshake cannot reach the result.
  generic_adder #(.K(K)) u_adder (
    .a   (op_a_reg),
    .b   (op_b_reg),
    .sum (adder_sum)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      op_a_reg       <= '0;
      op_b_reg       <= '0;
      op_id_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_sum_reg   <= '0;
      resp_id_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A grant implies the matching valid, so a grant is a handshake.
          if (grant0) begin
            op_a_reg       <= req0_a;
            op_b_reg       <= req0_b;
            op_id_reg      <= 1'b0;
            last_grant_reg <= 1'b0;
            state_reg      <= ADD;
          end else if (grant1) begin
            op_a_reg       <= req1_a;
            op_b_reg       <= req1_b;
            op_id_reg      <= 1'b1;
            last_grant_reg <= 1'b1;
            state_reg      <= ADD;
          end
        end
        ADD: begin
          resp_sum_reg   <= adder_sum;
          resp_id_reg    <= op_id_reg;
          resp_valid_reg <= 1'b1;
          state_reg      <= RESP;
        end
        RESP: begin
          // Sum and id hold their values until the consumer takes them.
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            state_reg      <= IDLE;
          end
        end
        default: begin
          resp_valid_reg <= 1'b0;
          state_reg      <= IDLE;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_sum   = resp_sum_reg;
  assign resp_id    = resp_id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int K = 6;

  logic         clk;
  logic         resetn;
  logic         req0_valid;
  logic [K-1:0] req0_a;
  logic [K-1:0] req0_b;
  logic         req0_ready;
  logic         req1_valid;
  logic [K-1:0] req1_a;
  logic [K-1:0] req1_b;
  logic         req1_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [K:0]   resp_sum;
  logic         resp_id;

  int n_checks;
  int n_pass;

  adder_arbiter #(.K(K)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  // Waits (bounded) for a cycle with a ready; returns 0/1 for the granted
  // requester, 2 if both readys were seen together, -1 on timeout. Returns
  // just after the handshake edge.
  task automatic wait_hs(output int who);
    who = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req0_ready && req1_ready) begin
        who = 2;
        break;
      end else if (req0_ready && req0_valid) begin
        who = 0;
        break;
      end else if (req1_ready && req1_valid) begin
        who = 1;
        break;
      end
    end
    tick();
  endtask

  // Counts negedges until resp_valid (99 on timeout) and any ready seen
  // meanwhile. Returns at the negedge where resp_valid was seen.
  task automatic wait_resp(output int lat, output int viol);
    lat  = 99;
    viol = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) viol++;
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn     = 1'b0;
    req0_valid = 1'b1;
    req0_a     = 6'd3;
    req0_b     = 6'd4;
    req1_valid = 1'b1;
    req1_a     = 6'd5;
    req1_b     = 6'd6;
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ((req0_ready !== 1'b0) || (req1_ready !== 1'b0))
      $display("FAIL reset_ready: got r0=%b r1=%b expected 0 0", req0_ready, req1_ready);
    else n_pass++;
    n_checks++;
    if ((resp_valid !== 1'b0) || (resp_sum !== 7'd0) || (resp_id !== 1'b0))
      $display("FAIL reset_resp: got valid=%b sum=%0d id=%b expected 0 0 0",
               resp_valid, resp_sum, resp_id);
    else n_pass++;
    tick();
    resetn = 1'b1;
    @(negedge clk);
    // last_grant resets to 1, so requester 0 wins the first contention.
    n_checks++;
    if ((req0_ready !== 1'b1) || (req1_ready !== 1'b0))
      $display("FAIL reset_first_grant: got r0=%b r1=%b expected 1 0", req0_ready, req1_ready);
    else n_pass++;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    $display("reset: readys=%b%b after release", req0_ready, req1_ready);
  endtask

  task automatic test_single();
    int who, lat, viol;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req0_a     = 6'd63;
    req0_b     = 6'd63;
    wait_hs(who);
    req0_valid = 1'b0;
    n_checks++;
    if (who !== 0) $display("FAIL single_grant: got %0d expected 0", who);
    else n_pass++;
    wait_resp(lat, viol);
    n_checks++;
    if (lat !== 2) $display("FAIL single_latency: got %0d expected 2", lat);
    else n_pass++;
    n_checks++;
    if ((resp_sum !== 7'd126) || (resp_id !== 1'b0))
      $display("FAIL single_sum: got sum=%0d id=%b expected 126 0", resp_sum, resp_id);
    else n_pass++;
    $display("single: a=63 b=63 sum=%0d id=%b", resp_sum, resp_id);
    tick();
  endtask

  task automatic test_contention();
    int who, lat, viol;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req0_a     = 6'd1;
    req0_b     = 6'd2;
    req1_valid = 1'b1;
    req1_a     = 6'd5;
    req1_b     = 6'd9;
    wait_hs(who);
    req0_valid = 1'b0;
    n_checks++;
    if (who !== 0) $display("FAIL contention_first: got %0d expected 0", who);
    else n_pass++;
    wait_resp(lat, viol);
    n_checks++;
    if ((lat !== 2) || (viol !== 0) || (resp_sum !== 7'd3) || (resp_id !== 1'b0))
      $display("FAIL contention_resp0: got lat=%0d viol=%0d sum=%0d id=%b expected 2 0 3 0",
               lat, viol, resp_sum, resp_id);
    else n_pass++;
    $display("contention: first sum=%0d id=%b", resp_sum, resp_id);
    tick();
    wait_hs(who);
    req1_valid = 1'b0;
    n_checks++;
    if (who !== 1) $display("FAIL contention_second: got %0d expected 1", who);
    else n_pass++;
    wait_resp(lat, viol);
    n_checks++;
    if ((lat !== 2) || (viol !== 0) || (resp_sum !== 7'd14) || (resp_id !== 1'b1))
      $display("FAIL contention_resp1: got lat=%0d viol=%0d sum=%0d id=%b expected 2 0 14 1",
               lat, viol, resp_sum, resp_id);
    else n_pass++;
    $display("contention: second sum=%0d id=%b", resp_sum, resp_id);
    tick();
  endtask

  task automatic test_sustained();
    logic [K-1:0] ta [8];
    logic [K-1:0] tb [8];
    logic [K:0]   te [8];
    int who, lat, viol;
    // Even ops go to requester 0, odd ops to requester 1.
    ta = '{6'd10, 6'd40, 6'd63, 6'd0, 6'd33, 6'd50, 6'd7, 6'd63};
    tb = '{6'd11, 6'd23, 6'd62, 6'd1, 6'd31, 6'd50, 6'd0, 6'd63};
    te = '{7'd21, 7'd63, 7'd125, 7'd1, 7'd64, 7'd100, 7'd7, 7'd126};
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if ((i % 2) == 0) begin
        req0_a = ta[i];
        req0_b = tb[i];
        req1_a = 6'(i);
        req1_b = 6'(i);
      end else begin
        req1_a = ta[i];
        req1_b = tb[i];
        req0_a = 6'(i);
        req0_b = 6'(i);
      end
      wait_hs(who);
      n_checks++;
      if (who !== (i % 2)) $display("FAIL sustained_grant%0d: got %0d expected %0d", i, who, i % 2);
      else n_pass++;
      wait_resp(lat, viol);
      n_checks++;
      if ((viol !== 0) || (resp_sum !== te[i]) || (resp_id !== 1'(i % 2)))
        $display("FAIL sustained_resp%0d: got viol=%0d sum=%0d id=%b expected 0 %0d %0d",
                 i, viol, resp_sum, resp_id, te[i], i % 2);
      else n_pass++;
      $display("sustained op %0d: sum=%0d id=%b", i, resp_sum, resp_id);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int who, lat, viol;
    int bad;
    do_reset();
    resp_ready = 1'b0;
    req0_valid = 1'b1;
    req0_a     = 6'd10;
    req0_b     = 6'd20;
    wait_hs(who);
    n_checks++;
    if (who !== 0) $display("FAIL backpressure_grant: got %0d expected 0", who);
    else n_pass++;
    // Change operands before the add edge; the latched pair must be used.
    req0_a     = 6'd55;
    req1_valid = 1'b1;
    req1_a     = 6'd2;
    req1_b     = 6'd2;
    wait_resp(lat, viol);
    n_checks++;
    if ((lat !== 2) || (viol !== 0) || (resp_sum !== 7'd30))
      $display("FAIL backpressure_first: got lat=%0d viol=%0d sum=%0d expected 2 0 30",
               lat, viol, resp_sum);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      req0_a = 6'(i * 9 + 1);
      @(negedge clk);
      n_checks++;
      if ((resp_valid !== 1'b1) || (resp_sum !== 7'd30) || (resp_id !== 1'b0) ||
          (req0_ready !== 1'b0) || (req1_ready !== 1'b0))
        $display("FAIL backpressure_hold%0d: got valid=%b sum=%0d id=%b r0=%b r1=%b expected 1 30 0 0 0",
                 i, resp_valid, resp_sum, resp_id, req0_ready, req1_ready);
      else n_pass++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL backpressure_single_delivery: got %0d extra valid cycles expected 0", bad);
    else n_pass++;
    $display("backpressure: sum=30 delivered once");
  endtask

  task automatic test_boundary();
    logic [K-1:0] ba [3];
    logic [K-1:0] bb [3];
    logic [K:0]   be [3];
    int who, lat, viol;
    ba = '{6'd0, 6'd32, 6'd63};
    bb = '{6'd0, 6'd32, 6'd1};
    be = '{7'd0, 7'd64, 7'd64};
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1;
      req1_a     = ba[i];
      req1_b     = bb[i];
      wait_hs(who);
      req1_valid = 1'b0;
      wait_resp(lat, viol);
      n_checks++;
      if ((who !== 1) || (lat !== 2) || (resp_sum !== be[i]) || (resp_id !== 1'b1))
        $display("FAIL boundary%0d: got who=%0d lat=%0d sum=%0d id=%b expected 1 2 %0d 1",
                 i, who, lat, resp_sum, resp_id, be[i]);
      else n_pass++;
      $display("boundary: a=%0d b=%0d sum=%0d carry=%b", ba[i], bb[i], resp_sum, resp_sum[K]);
      tick();
    end
  endtask

  task automatic test_mid_reset();
    int who, lat, viol;
    int bad;
    do_reset();
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req0_a     = 6'd7;
    req0_b     = 6'd8;
    wait_hs(who);
    // Now in ADD; req0_valid is left high so ready gating under reset shows.
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ((resp_valid !== 1'b0) || (req0_ready !== 1'b0) || (req1_ready !== 1'b0))
      $display("FAIL midreset_immediate: got valid=%b r0=%b r1=%b expected 0 0 0",
               resp_valid, req0_ready, req1_ready);
    else n_pass++;
    tick();
    @(negedge clk);
    n_checks++;
    if ((resp_valid !== 1'b0) || (resp_sum !== 7'd0))
      $display("FAIL midreset_held: got valid=%b sum=%0d expected 0 0", resp_valid, resp_sum);
    else n_pass++;
    req0_valid = 1'b0;
    tick();
    resetn = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midreset_no_stale: got %0d valid cycles expected 0", bad);
    else n_pass++;
    req1_valid = 1'b1;
    req1_a     = 6'd4;
    req1_b     = 6'd5;
    wait_hs(who);
    req1_valid = 1'b0;
    wait_resp(lat, viol);
    n_checks++;
    if ((who !== 1) || (lat !== 2) || (resp_sum !== 7'd9) || (resp_id !== 1'b1))
      $display("FAIL midreset_new_req: got who=%0d lat=%0d sum=%0d id=%b expected 1 2 9 1",
               who, lat, resp_sum, resp_id);
    else n_pass++;
    $display("midreset: new req1 sum=%0d id=%b", resp_sum, resp_id);
    tick();
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    resetn     = 1'b0;
    req0_valid = 1'b0;
    req0_a     = '0;
    req0_b     = '0;
    req1_valid = 1'b0;
    req1_a     = '0;
    req1_b     = '0;
    resp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_sustained();
    test_backpressure();
    test_boundary();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
